// File: rtl/cpu_types_pkg.sv
// Shared CPU/memory types: word and RAM status, controller states, and the
// transaction kinds the arbiter can grant.
package cpu_types_pkg;
  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;

  typedef enum logic [2:0] {IDLE, IFETCH, DWRITE, SNOOP, DREAD, C2C} mcstate_t;

  typedef enum logic [1:0] {XACT_NONE, XACT_IFETCH, XACT_DWRITE, XACT_DREAD} xact_t;
endpackage

// File: rtl/cache_control_if.sv
// Bundle between the per-core caches, the coherence logic and the single RAM
// port; the cc modport is the memory controller's view.
interface cache_control_if #(
  parameter int CPUS = 2
);
  import cpu_types_pkg::*;

  logic [CPUS-1:0] iwait, dwait, iREN, dREN, dWEN;
  word_t           iload [CPUS];
  word_t           dload [CPUS];
  word_t           dstore [CPUS];
  word_t           iaddr [CPUS];
  word_t           daddr [CPUS];

  logic [CPUS-1:0] ccwait, ccinv, ccwrite, cctrans;
  word_t           ccsnoopaddr [CPUS];

  logic            ramWEN, ramREN;
  ramstate_t       ramstate;
  word_t           ramaddr, ramstore, ramload;

  modport cc (
    input  iREN, dREN, dWEN, dstore, iaddr, daddr,
    input  ccwrite, cctrans,
    input  ramstate, ramload,
    output iwait, dwait, iload, dload,
    output ccwait, ccinv, ccsnoopaddr,
    output ramWEN, ramREN, ramaddr, ramstore
  );
endinterface

// File: rtl/mc_arbiter.sv
// Combinational grant for two cores: writebacks beat data reads beat fetches,
// and the round-robin pointer settles ties within a level.
module mc_arbiter
  import cpu_types_pkg::*;
(
  input  logic [1:0] i_iren,
  input  logic [1:0] i_dren,
  input  logic [1:0] i_dwen,
  input  logic       i_rr,
  output logic       o_cpu,
  output xact_t      o_xact
);
  function automatic logic pick(input logic [1:0] v, input logic rr);
    return v[rr] ? rr : ~rr;
  endfunction

  always_comb begin
    o_cpu  = 1'b0;
    o_xact = XACT_NONE;
    if (|i_dwen) begin
      o_xact = XACT_DWRITE;
      o_cpu  = pick(i_dwen, i_rr);
    end else if (|i_dren) begin
      o_xact = XACT_DREAD;
      o_cpu  = pick(i_dren, i_rr);
    end else if (|i_iren) begin
      o_xact = XACT_IFETCH;
      o_cpu  = pick(i_iren, i_rr);
    end
  end
endmodule

// File: rtl/memory_control.sv
// Memory controller: serialises two cores' fetch/load/writeback traffic onto
// one RAM port and runs a snoop ahead of every data read.
module memory_control
  import cpu_types_pkg::*;
#(
  parameter int CPUS = 2
) (
  input logic         CLK,
  input logic         nRST,
  cache_control_if.cc ccif
);
  mcstate_t r_state;
  logic     r_cpu;
  logic     r_rr;
  word_t    r_addr;
  word_t    r_store;
  logic     w_oth;
  logic     w_cpu;
  xact_t    w_xact;
  logic     w_access;
  logic     w_snoop_hit;

  assign w_oth       = ~r_cpu;
  assign w_access    = (ccif.ramstate == ACCESS);
  assign w_snoop_hit = ccif.cctrans[w_oth] & ccif.dWEN[w_oth];

  mc_arbiter u_arb (
    .i_iren (ccif.iREN),
    .i_dren (ccif.dREN),
    .i_dwen (ccif.dWEN),
    .i_rr   (r_rr),
    .o_cpu  (w_cpu),
    .o_xact (w_xact)
  );

  // Address and store data are captured at grant so the RAM sees stable values
  // while it is busy, even if the requester changes or drops its request.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state <= IDLE;
      r_cpu   <= 1'b0;
      r_rr    <= 1'b0;
      r_addr  <= '0;
      r_store <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_cpu <= w_cpu;
          case (w_xact)
            XACT_DWRITE: begin
              r_state <= DWRITE;
              r_addr  <= ccif.daddr[w_cpu];
              r_store <= ccif.dstore[w_cpu];
            end
            XACT_DREAD: begin
              r_state <= SNOOP;
              r_addr  <= ccif.daddr[w_cpu];
            end
            XACT_IFETCH: begin
              r_state <= IFETCH;
              r_addr  <= ccif.iaddr[w_cpu];
            end
            default: ;
          endcase
        end
        SNOOP: begin
          if (w_snoop_hit) begin
            r_state <= C2C;
            r_store <= ccif.dstore[w_oth];
          end else begin
            r_state <= DREAD;
          end
        end
        IFETCH: if (w_access) r_state <= IDLE;
        DWRITE, DREAD, C2C: begin
          if (w_access) begin
            r_state <= IDLE;
            r_rr    <= w_oth;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Completion is combinational on ACCESS so the core sees RAM data that cycle.
  always_comb begin
    ccif.iwait    = '1;
    ccif.dwait    = '1;
    ccif.ccwait   = '0;
    ccif.ccinv    = '0;
    ccif.ramREN   = 1'b0;
    ccif.ramWEN   = 1'b0;
    ccif.ramaddr  = '0;
    ccif.ramstore = '0;
    for (int c = 0; c < CPUS; c++) begin
      ccif.iload[c]       = '0;
      ccif.dload[c]       = '0;
      ccif.ccsnoopaddr[c] = '0;
    end
    case (r_state)
      IFETCH: begin
        ccif.ramREN  = 1'b1;
        ccif.ramaddr = r_addr;
        if (w_access) begin
          ccif.iwait[r_cpu] = 1'b0;
          ccif.iload[r_cpu] = ccif.ramload;
        end
      end
      DREAD: begin
        ccif.ramREN  = 1'b1;
        ccif.ramaddr = r_addr;
        if (w_access) begin
          ccif.dwait[r_cpu] = 1'b0;
          ccif.dload[r_cpu] = ccif.ramload;
        end
      end
      DWRITE: begin
        ccif.ramWEN   = 1'b1;
        ccif.ramaddr  = r_addr;
        ccif.ramstore = r_store;
        if (w_access) ccif.dwait[r_cpu] = 1'b0;
      end
      SNOOP, C2C: begin
        ccif.ccwait[w_oth]      = 1'b1;
        ccif.ccinv[w_oth]       = ccif.ccwrite[r_cpu];
        ccif.ccsnoopaddr[w_oth] = r_addr;
        if (r_state == C2C) begin
          ccif.ramWEN   = 1'b1;
          ccif.ramaddr  = r_addr;
          ccif.ramstore = r_store;
          if (w_access) begin
            ccif.dwait        = '0;
            ccif.dload[r_cpu] = r_store;
          end
        end
      end
      default: ;
    endcase
  end
endmodule

// File: doc/memory_control.md
MEMORY_CONTROL -- requirements
Module: memory_control

Interface
REQ-001 SHALL have parameter CPUS, default 2, the number of cores served; the design is exercised only at 2.
REQ-002 SHALL have port CLK, input, 1 bit: the single clock, rising-edge.
REQ-003 SHALL have port nRST, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port ccif, cache_control_if.cc modport: the per-CPU cache request/response, coherence and RAM signal bundle (word_t = 32 bit).

Function
REQ-005 SHALL serve exactly one transaction at a time; each transaction moves one word.
REQ-006 SHALL arbitrate in IDLE with this priority: any dWEN (writeback), then any dREN, then any iREN.
REQ-007 SHALL break ties between CPUs at the same priority level with a 1-bit round-robin pointer rr; rr toggles after each completed d-transaction and points away from the CPU just served.
REQ-008 SHALL use states IDLE, IFETCH, DWRITE, SNOOP, DREAD, C2C (cache-to-cache).
REQ-009 SHALL sequence states as follows:
- IDLE->DWRITE on a dWEN grant.
- IDLE->SNOOP on a dREN grant.
- IDLE->IFETCH on an iREN grant.
- SNOOP->C2C if the other CPU has cctrans=1 and dWEN=1; otherwise SNOOP->DREAD.
- IFETCH, DWRITE, DREAD and C2C return to IDLE the cycle after ramstate==ACCESS.
REQ-010 SHALL drive the following in SNOOP, for granted CPU i and other CPU j:
- ccwait[j]=1
- ccsnoopaddr[j]=daddr[i]
- ccinv[j]=ccwrite[i]
REQ-011 SHALL hold ccwait[j] through C2C.
REQ-012 SHALL drive the RAM per state:
- IFETCH: ramREN=1, ramaddr=iaddr[i].
- DREAD: ramREN=1, ramaddr=daddr[i].
- DWRITE: ramWEN=1, ramaddr=daddr[i], ramstore=dstore[i].
- C2C: ramWEN=1, ramaddr=daddr[i], ramstore=dstore[j]; dload[i]=dstore[j].
REQ-013 SHALL hold ramaddr and ramstore stable while ramstate is BUSY.
REQ-014 SHALL complete a transaction combinationally in the cycle ramstate==ACCESS, for exactly one cycle:
- iwait[i]=0, iload[i]=ramload for IFETCH.
- dwait[i]=0, dload[i]=ramload for DREAD.
- dwait[i]=0 for DWRITE.
- dwait[i]=0 and dwait[j]=0 for C2C.
REQ-015 SHALL hold iwait and dwait at 1 at all other times; iload and dload are 0 when not completing.
REQ-016 SHALL treat ramstate FREE, BUSY and ERROR as not-ready and keep the state with requests asserted (retry).
REQ-017 SHALL complete an in-flight transaction even if the requester drops its request mid-transaction.
REQ-018 SHALL serve a request arriving during a transaction only after the return to IDLE.
REQ-019 SHALL NOT assert ramREN and ramWEN in the same cycle.
REQ-020 SHALL hold ccwait, ccinv and ccsnoopaddr at 0 outside SNOOP and C2C.
REQ-021 SHALL have a minimum latency, with ramstate ACCESS immediately, of:
- 1 cycle for an ifetch or writeback;
- 2 cycles for a dread.

Reset
REQ-022 SHALL, on nRST=0 and asynchronously, force state=IDLE and rr=0.
REQ-023 SHALL hold these output values while in reset:
- iwait=dwait=all 1s;
- ramREN=ramWEN=0;
- ccwait=ccinv=0;
- ramaddr, ramstore, iload, dload, ccsnoopaddr all 0.
REQ-024 SHALL abandon any in-flight transaction on reset mid-operation, with no completion pulse.

Structure
REQ-025 SHALL take word_t and ramstate_t from cpu_types_pkg.
REQ-026 SHALL add to cpu_types_pkg the mcstate_t enum for the six states, shared with benches.
REQ-027 SHALL use a sub-module mc_arbiter: combinational priority and round-robin grant from iREN/dREN/dWEN/rr, producing the grant CPU and transaction type.

Verification
REQ-028 The bench SHALL cover an ifetch: CPU0 iREN, iaddr=0x100, RAM 2 BUSY then ACCESS with ramload=0xDEAD -> iwait[0]=0, iload[0]=0xDEAD on cycle 3 only.
REQ-029 The bench SHALL cover a write/fetch collision: same cycle CPU1 dWEN daddr=0x200 dstore=0x55 and CPU0 iREN -> ramWEN first with ramaddr 0x200, then IFETCH.
REQ-030 The bench SHALL cover an invalidating snoop: CPU0 dREN daddr=0x300 ccwrite=1 -> SNOOP cycle with ccwait[1]=1, ccsnoopaddr[1]=0x300, ccinv[1]=1; CPU1 idle -> DREAD.
REQ-031 The bench SHALL cover cache-to-cache: CPU0 dREN 0x300, CPU1 responds cctrans=1 dWEN=1 dstore=0xBEEF -> ramWEN with ramstore=0xBEEF, dload[0]=0xBEEF, dwait[0]=dwait[1]=0 at ACCESS.
REQ-032 The bench SHALL cover fairness: both CPUs hold dREN for 4 transactions -> grants alternate 0,1,0,1.
REQ-033 The bench SHALL cover reset mid-DREAD: nRST low in DREAD -> ramREN=0 immediately, dwait all 1, state IDLE, no completion pulse.
